sp_store_engine: RTL and testbench
==================================

// Module: sp_store_engine
// PURPOSE
//  Initiator and drain for the store path of one scratchpad bank. Accepts a store
//  command (matrix select + DRAM base address) and pushes 4 row-read requests
//  (mat_t=2'b00) into the bank rFIFO. Independently pops the bank dramFIFO and
//  presents each row as a DRAM write beat. Pulses store_done when row 3 of a
//  store is accepted by DRAM. Sits between the instruction scheduler and the
//  bank/DRAM interface.
// PARAMETERS
//  BYTES_PER_ROW  8  DRAM byte stride between rows (BITS_PER_ROW/8)
//  ROWS_PER_MAT   4  rows per matrix; rows 0..ROWS_PER_MAT-1 are issued
// PORTS
//  CLK              in   1             clock, all state on posedge
//  nRST             in   1             asynchronous active-low reset
//  store_valid      in   1             store command valid
//  store_ready      out  1             engine can accept a command
//  store_mat_s      in   MAT_S_W       matrix select to store
//  store_addr       in   32            DRAM byte address of row 0
//  rFIFO_WEN        out  1             push request into bank rFIFO
//  rFIFO_wdata      out  rFIFO_t       {mat_t=00, mat_s, row_s, addr}
//  rFIFO_full       in   1             bank rFIFO full
//  dramFIFO_REN     out  1             pop bank dramFIFO
//  dramFIFO_empty   in   1             bank dramFIFO empty
//  dramFIFO_rdata   in   dramFIFO_t    {addr, mat_s, row_s, data}
//  dram_wen         out  1             DRAM write beat valid
//  dram_addr        out  32            DRAM byte address of beat
//  dram_wdata       out  BITS_PER_ROW  row data
//  dram_ready       in   1             DRAM accepts beat this cycle
//  store_done       out  1             1-cycle pulse: row ROWS_PER_MAT-1 accepted
//  busy             out  1             any store in flight
// BEHAVIOUR
//  Reset: FSM=IDLE, row_cnt=0, beat register invalid; all outputs 0 except
//   store_ready=1. Reset mid-store discards everything; no partial pulse.
//  Issue FSM: IDLE, ISSUE.
//   IDLE: store_ready=1; store_valid latches mat_s/addr, row_cnt=0 -> ISSUE.
//   ISSUE: store_ready=0; when !rFIFO_full: rFIFO_WEN=1, row_s=row_cnt,
//    addr=base+row_cnt*BYTES_PER_ROW (32-bit wrap), mat_t=2'b00; row_cnt++.
//    After pushing row ROWS_PER_MAT-1 -> IDLE next cycle. rFIFO_full stalls,
//    row_cnt holds, rFIFO_WEN=0 (never push while full). 1 row/cycle max.
//   Command accept to first push: 1 cycle. Back-to-back stores: ready again the
//    cycle after last push.
//  Drain: single-entry beat register, independent of issue FSM.
//   dramFIFO_REN=1 iff !dramFIFO_empty && (!beat_valid || dram_ready); popped
//    entry loads register next edge (addr, data, row_s captured).
//   dram_wen=beat_valid; dram_addr/dram_wdata held stable while dram_wen &&
//    !dram_ready. Accept+pop same cycle gives 1 beat/cycle throughput.
//  store_done: registered, asserted the cycle after a beat with
//   row_s==ROWS_PER_MAT-1 is accepted (dram_wen && dram_ready).
//  busy = (FSM!=IDLE) || beat_valid || !dramFIFO_empty.
//  Order: rows leave in push order; engine relies on bank FIFO ordering and
//   never reorders. dramFIFO_REN never asserted while empty.
// TESTING
//  1. mat_s=2, addr=0x1000, no stalls -> rFIFO pushes row0..3 addr 0x1000,
//     0x1008,0x1010,0x1018 on 4 consecutive cycles; store_ready=0 throughout.
//  2. rFIFO_full high 3 cycles after row1 -> no push while full; row2 follows
//     deassert, no duplicate or skipped row.
//  3. dramFIFO preloaded 4 beats, dram_ready=1 -> 4 dram_wen beats back-to-back,
//     data/addr match; store_done one cycle after row3 beat, exactly once.
//  4. dram_ready low 5 cycles on beat 2 -> dram_addr/wdata stable, no pop,
//     dramFIFO_REN=0 until accept.
//  5. addr=0xFFFF_FFF8 -> row1 addr wraps to 0x0000_0000.
//  6. nRST low during ISSUE after row1 -> outputs reset, store_ready=1, no
//     store_done; new command starts at row0.

Source files
------------

// File: rtl/sp_store_engine.sv
// sp_store_engine: store-path initiator (rFIFO row reads) and drain (dramFIFO -> DRAM beats) for one bank.
// Latency: command accept -> first rFIFO push 1 cycle; dramFIFO pop -> DRAM beat 1 cycle; accept of last row -> store_done 1 cycle.
// Backpressure: rFIFO_full stalls row issue in place; dram_ready low holds the beat register and blocks further pops.
//
// Ports:
//   CLK, nRST                          clock, async active-low reset
//   store_valid/ready, store_mat_s,    store command handshake, matrix select,
//   store_addr                         DRAM byte address of row 0
//   rFIFO_WEN, rFIFO_wdata, rFIFO_full row-read request push into the bank rFIFO
//   dramFIFO_REN/empty/rdata           pop side of the bank dramFIFO
//   dram_wen/addr/wdata/ready          DRAM write beat (held while !dram_ready)
//   store_done                         pulse after last row of a store is accepted
//   busy                               any store activity in flight
module sp_store_engine #(
  parameter  int MAT_S_W       = 2,
  parameter  int BITS_PER_ROW  = 64,
  parameter  int BYTES_PER_ROW = BITS_PER_ROW / 8,
  parameter  int ROWS_PER_MAT  = 4,
  localparam int ROW_S_W       = (ROWS_PER_MAT > 1) ? $clog2(ROWS_PER_MAT) : 1,
  localparam int RFIFO_W       = 2 + MAT_S_W + ROW_S_W + 32,
  localparam int DFIFO_W       = 32 + MAT_S_W + ROW_S_W + BITS_PER_ROW
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    store_valid,
  output logic                    store_ready,
  input  logic [MAT_S_W-1:0]      store_mat_s,
  input  logic [31:0]             store_addr,
  output logic                    rFIFO_WEN,
  output logic [RFIFO_W-1:0]      rFIFO_wdata,
  input  logic                    rFIFO_full,
  output logic                    dramFIFO_REN,
  input  logic                    dramFIFO_empty,
  input  logic [DFIFO_W-1:0]      dramFIFO_rdata,
  output logic                    dram_wen,
  output logic [31:0]             dram_addr,
  output logic [BITS_PER_ROW-1:0] dram_wdata,
  input  logic                    dram_ready,
  output logic                    store_done,
  output logic                    busy
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [ROW_S_W-1:0] LAST_ROW = ROW_S_W'(ROWS_PER_MAT - 1);

  state_t               state, state_nxt;
  logic [ROW_S_W-1:0]   row_cnt;
  logic [MAT_S_W-1:0]   mat_q;
  logic [31:0]          base_q;
  logic [31:0]          row_off;
  logic                 push;

  // ---------------- issue FSM ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (store_valid) state_nxt = ISSUE;
      ISSUE:   if (!rFIFO_full && row_cnt == LAST_ROW) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    store_ready = (state == IDLE);
    push        = (state == ISSUE) && !rFIFO_full;
    rFIFO_WEN   = push;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      row_cnt <= '0;
      mat_q   <= '0;
      base_q  <= '0;
    end else if (state == IDLE && store_valid) begin
      row_cnt <= '0;
      mat_q   <= store_mat_s;
      base_q  <= store_addr;
    end else if (push) begin
      // explicit wrap keeps non-power-of-two row counts correct
      row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
    end
  end

  // row address wraps modulo 2^32
  assign row_off     = 32'(row_cnt) * 32'(BYTES_PER_ROW);
  assign rFIFO_wdata = {2'b00, mat_q, row_cnt, base_q + row_off};

  // ---------------- drain: single-entry beat register ----------------
  logic                    beat_valid;
  logic [ROW_S_W-1:0]      beat_row;
  logic [31:0]             ent_addr;
  logic [ROW_S_W-1:0]      ent_row;
  logic [BITS_PER_ROW-1:0] ent_data;
  logic [MAT_S_W-1:0]      unused_ent_mat;

  assign ent_addr       = dramFIFO_rdata[DFIFO_W-1 -: 32];
  assign unused_ent_mat = dramFIFO_rdata[BITS_PER_ROW + ROW_S_W +: MAT_S_W];
  assign ent_row        = dramFIFO_rdata[BITS_PER_ROW +: ROW_S_W];
  assign ent_data       = dramFIFO_rdata[BITS_PER_ROW-1:0];

  // pop whenever the register is free or being emptied this cycle
  assign dramFIFO_REN = !dramFIFO_empty && (!beat_valid || dram_ready);
  assign dram_wen     = beat_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      beat_valid <= 1'b0;
      beat_row   <= '0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      store_done <= 1'b0;
    end else begin
      store_done <= beat_valid && dram_ready && (beat_row == LAST_ROW);
      if (dramFIFO_REN) begin
        beat_valid <= 1'b1;
        beat_row   <= ent_row;
        dram_addr  <= ent_addr;
        dram_wdata <= ent_data;
      end else if (dram_ready) begin
        beat_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE) || beat_valid || !dramFIFO_empty;

endmodule

// File: tb/tb_sp_store_engine.sv
// tb_sp_store_engine: directed scenarios plus random traffic against a queue-based reference model.
// Latency: checks every cycle #1 after the falling edge, when the inputs for that cycle are stable.
// Backpressure: randomly stalls rFIFO_full and dram_ready and randomly refills the emulated dramFIFO.
module tb_sp_store_engine;

  localparam int MAT_S_W = 2;
  localparam int BITS    = 64;
  localparam int ROWS    = 4;
  localparam int STRIDE  = 8;

  typedef struct packed {
    logic [1:0]  mat;
    logic [1:0]  row;
    logic [31:0] addr;
  } push_t;

  typedef struct packed {
    logic [31:0]     addr;
    logic [1:0]      mat;
    logic [1:0]      row;
    logic [BITS-1:0] data;
  } dent_t;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              store_valid;
  logic              store_ready;
  logic [1:0]        store_mat_s;
  logic [31:0]       store_addr;
  logic              rFIFO_WEN;
  logic [37:0]       rFIFO_wdata;
  logic              rFIFO_full;
  logic              dramFIFO_REN;
  logic              dramFIFO_empty;
  logic [99:0]       dramFIFO_rdata;
  logic              dram_wen;
  logic [31:0]       dram_addr;
  logic [BITS-1:0]   dram_wdata;
  logic              dram_ready;
  logic              store_done;
  logic              busy;

  sp_store_engine #(.MAT_S_W(MAT_S_W), .BITS_PER_ROW(BITS), .ROWS_PER_MAT(ROWS)) dut (
    .CLK(CLK), .nRST(nRST),
    .store_valid(store_valid), .store_ready(store_ready),
    .store_mat_s(store_mat_s), .store_addr(store_addr),
    .rFIFO_WEN(rFIFO_WEN), .rFIFO_wdata(rFIFO_wdata), .rFIFO_full(rFIFO_full),
    .dramFIFO_REN(dramFIFO_REN), .dramFIFO_empty(dramFIFO_empty), .dramFIFO_rdata(dramFIFO_rdata),
    .dram_wen(dram_wen), .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_ready(dram_ready),
    .store_done(store_done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  push_t pq[$];    // row requests still owed to the rFIFO
  dent_t fq[$];    // contents of the emulated bank dramFIFO
  dent_t oq[$];    // popped rows not yet accepted by DRAM
  logic  exp_done;
  int    fill_row;

  // per-cycle stimulus
  logic        s_valid, s_full, s_dready, s_fill;
  logic [1:0]  s_mat;
  logic [31:0] s_addr;

  function automatic dent_t rand_entry(input int row);
    dent_t e;
    e.addr = $urandom;
    e.mat  = 2'($urandom);
    e.row  = 2'(row);
    e.data = {$urandom, $urandom};
    return e;
  endfunction

  task automatic step();
    logic exp_ready, exp_ren;
    @(negedge CLK);
    store_valid    = s_valid;
    store_mat_s    = s_mat;
    store_addr     = s_addr;
    rFIFO_full     = s_full;
    dram_ready     = s_dready;
    dramFIFO_empty = (fq.size() == 0);
    dramFIFO_rdata = (fq.size() != 0) ? fq[0] : '0;
    #1;
    exp_ready = (pq.size() == 0);
    exp_ren   = (fq.size() != 0) && ((oq.size() == 0) || s_dready);
    chk("store_ready", store_ready, exp_ready);
    chk("rfifo_wen", rFIFO_WEN, (pq.size() != 0) && !s_full);
    if (rFIFO_WEN && pq.size() != 0)
      chk("rfifo_wdata", rFIFO_wdata, {2'b00, pq[0].mat, pq[0].row, pq[0].addr});
    chk("dram_wen", dram_wen, oq.size() != 0);
    if (dram_wen && oq.size() != 0) begin
      chk("dram_addr", dram_addr, oq[0].addr);
      chk("dram_wdata", dram_wdata, oq[0].data);
    end
    chk("dramfifo_ren", dramFIFO_REN, exp_ren);
    chk("store_done", store_done, exp_done);
    chk("busy", busy, (pq.size() != 0) || (oq.size() != 0) || (fq.size() != 0));

    // advance the model across the coming rising edge
    exp_done = 1'b0;
    if (oq.size() != 0 && s_dready) begin
      exp_done = (oq[0].row == 2'(ROWS - 1));
      void'(oq.pop_front());
    end
    if (exp_ren) oq.push_back(fq.pop_front());
    if (pq.size() != 0 && !s_full) void'(pq.pop_front());
    if (exp_ready && s_valid)
      for (int r = 0; r < ROWS; r++) begin
        push_t p;
        p.mat  = s_mat;
        p.row  = 2'(r);
        p.addr = s_addr + 32'(r * STRIDE);
        pq.push_back(p);
      end
    if (s_fill && fq.size() < 4) begin
      fq.push_back(rand_entry(fill_row));
      fill_row = (fill_row + 1) % ROWS;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    store_valid = 1'b0;
    rFIFO_full = 1'b0;
    dram_ready = 1'b0;
    dramFIFO_empty = 1'b1;
    dramFIFO_rdata = '0;
    pq.delete(); fq.delete(); oq.delete();
    exp_done = 1'b0;
    fill_row = 0;
    #1;
    chk("rst_store_ready", store_ready, 1'b1);
    chk("rst_rfifo_wen", rFIFO_WEN, 1'b0);
    chk("rst_dram_wen", dram_wen, 1'b0);
    chk("rst_ren", dramFIFO_REN, 1'b0);
    chk("rst_store_done", store_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dram_addr", dram_addr, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic idle_stim();
    s_valid = 1'b0; s_mat = 2'd0; s_addr = 32'h0;
    s_full = 1'b0; s_dready = 1'b1; s_fill = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] mat, input logic [31:0] addr);
    s_valid = 1'b1; s_mat = mat; s_addr = addr;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    store_valid = 1'b0; store_mat_s = '0; store_addr = '0;
    rFIFO_full = 1'b0; dramFIFO_empty = 1'b1; dramFIFO_rdata = '0; dram_ready = 1'b0;
    exp_done = 1'b0; fill_row = 0;
    idle_stim();
    do_reset();

    // four back-to-back row pushes from 0x1000
    cmd(2'd2, 32'h1000);
    repeat (6) step();

    // rFIFO_full for 3 cycles after row1
    cmd(2'd1, 32'h2000);
    repeat (2) step();
    s_full = 1'b1;
    repeat (3) step();
    s_full = 1'b0;
    repeat (4) step();

    // four preloaded beats, DRAM always ready
    for (int r = 0; r < ROWS; r++) fq.push_back(rand_entry(r));
    repeat (7) step();

    // DRAM stalls 5 cycles on beat 2
    for (int r = 0; r < ROWS; r++) fq.push_back(rand_entry(r));
    repeat (2) step();
    s_dready = 1'b0;
    repeat (5) step();
    s_dready = 1'b1;
    repeat (6) step();

    // address wrap past 0xFFFF_FFFF
    cmd(2'd3, 32'hFFFF_FFF8);
    repeat (5) step();

    // reset in the middle of issuing, with a beat pending
    for (int r = 0; r < ROWS; r++) fq.push_back(rand_entry(r));
    cmd(2'd0, 32'h3000);
    repeat (2) step();
    do_reset();
    chk("post_rst_ready", store_ready, 1'b1);
    cmd(2'd2, 32'h4000);
    repeat (6) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s_valid  = ($urandom_range(0, 3) == 0);
      s_mat    = 2'($urandom);
      s_addr   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      s_full   = ($urandom_range(0, 3) == 0);
      s_dready = ($urandom_range(0, 2) != 0);
      s_fill   = ($urandom_range(0, 1) == 0);
      step();
    end
    idle_stim();
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
